tile_ram_arbiter: RTL and testbench

Shares the single registered-read port of the 256×12 tile RAM (16×16 tile, 12-bit RGB, one-cycle read latency) between two requesters. The display side requests a full 16-pixel tile row, which the block issues as a sequenced burst. The accelerator side requests single-word reads. It sits directly in front of the tile RAM, drives its address, and tags returned data back to the owning requester.

---
 rtl/tile_ram_pkg.sv | 40 ++++
 rtl/tile_rd_pipe.sv | 122 ++++++++++++
 rtl/tile_ram_arbiter.sv | 159 +++++++++++++++
 tb/tb_tile_ram_arbiter.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tile_ram_pkg.sv
// ============================================================================
//  Module      : tile_ram_pkg
//  Description : Shared constants and types for the tile RAM arbiter:
//                tile geometry, RAM address width, default pixel width,
//                default key colour, arbiter state encoding and the read tag
//                carried alongside every issued RAM address.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package tile_ram_pkg;

    localparam int          TILE_DIM  = 16;
    localparam int          COL_W     = $clog2(TILE_DIM);
    localparam int          ADDR_W    = 8;
    localparam int          PIX_W     = 12;
    localparam logic [11:0] KEY_COLOR = 12'h247;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BURST  = 2'd1,
        SINGLE = 2'd2
    } state_t;

    typedef enum logic {
        OWN_DISP = 1'b0,
        OWN_ACC  = 1'b1
    } owner_t;

    // Identifies who a RAM word belongs to while it travels through the
    // read pipeline; col/last are only meaningful for display reads.
    typedef struct packed {
        owner_t           owner;
        logic [COL_W-1:0] col;
        logic             last;
    } rd_tag_t;

endpackage

`default_nettype wire

// File: rtl/tile_rd_pipe.sv
// ============================================================================
//  Module      : tile_rd_pipe
//  Description : Two-stage tag/valid pipeline that follows each address issued
//                to the tile RAM. Stage 1 lines the tag up with ram_data_out,
//                stage 2 registers the RAM word into the display or
//                accelerator output registers selected by the tag owner.
//                Synchronous clear drops everything in flight.
//  Config      : TILE_KEY_EN - when defined, a registered key-colour flag is
//                produced with each display pixel; otherwise disp_pix_key is 0.
//  Ports       : clock, reset          - clock / synchronous active-high clear
//                issue_valid/owner/col/last - tag of the address on the RAM
//                                        port this cycle
//                ram_data_out          - RAM word for last cycle's address
//                disp_*                - display pixel stream outputs
//                acc_valid, acc_data   - accelerator single-word outputs
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tile_rd_pipe #(
    parameter int PIX_W = tile_ram_pkg::PIX_W
`ifdef TILE_KEY_EN
    ,
    parameter logic [PIX_W-1:0] KEY_COLOR = tile_ram_pkg::KEY_COLOR
`endif
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           issue_valid,
    input  logic                           issue_owner,
    input  logic [tile_ram_pkg::COL_W-1:0] issue_col,
    input  logic                           issue_last,
    input  logic [PIX_W-1:0]               ram_data_out,
    output logic                           disp_pix_valid,
    output logic [PIX_W-1:0]               disp_pix,
    output logic [tile_ram_pkg::COL_W-1:0] disp_col,
    output logic                           disp_done,
    output logic                           disp_pix_key,
    output logic                           acc_valid,
    output logic [PIX_W-1:0]               acc_data
);
    import tile_ram_pkg::*;

    rd_tag_t          w_issue_tag;
    rd_tag_t          r_s1_tag;
    logic             r_s1_valid;
    logic             w_s1_disp;
    logic             w_s1_acc;

    logic             r_disp_valid;
    logic [PIX_W-1:0] r_disp_pix;
    logic [COL_W-1:0] r_disp_col;
    logic             r_disp_done;
    logic             r_acc_valid;
    logic [PIX_W-1:0] r_acc_data;

    assign w_issue_tag = '{owner: owner_t'(issue_owner), col: issue_col, last: issue_last};

    // Stage 1: tag aligned with the RAM read data of the same address.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_s1_tag   <= '0;
        end else begin
            r_s1_valid <= issue_valid;
            r_s1_tag   <= w_issue_tag;
        end
    end

    assign w_s1_disp = r_s1_valid && (r_s1_tag.owner == OWN_DISP);
    assign w_s1_acc  = r_s1_valid && (r_s1_tag.owner == OWN_ACC);

    // Stage 2: steer the RAM word to its owner. Data registers only load on
    // their own valid so each side keeps its last word between reads.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_disp_valid <= 1'b0;
            r_disp_pix   <= '0;
            r_disp_col   <= '0;
            r_disp_done  <= 1'b0;
            r_acc_valid  <= 1'b0;
            r_acc_data   <= '0;
        end else begin
            r_disp_valid <= w_s1_disp;
            r_disp_done  <= w_s1_disp && r_s1_tag.last;
            r_acc_valid  <= w_s1_acc;
            if (w_s1_disp) begin
                r_disp_pix <= ram_data_out;
                r_disp_col <= r_s1_tag.col;
            end
            if (w_s1_acc) begin
                r_acc_data <= ram_data_out;
            end
        end
    end

`ifdef TILE_KEY_EN
    logic r_disp_key;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_disp_key <= 1'b0;
        end else begin
            r_disp_key <= w_s1_disp && (ram_data_out == KEY_COLOR);
        end
    end

    assign disp_pix_key = r_disp_key;
`else
    assign disp_pix_key = 1'b0;
`endif

    assign disp_pix_valid = r_disp_valid;
    assign disp_pix       = r_disp_pix;
    assign disp_col       = r_disp_col;
    assign disp_done      = r_disp_done;
    assign acc_valid      = r_acc_valid;
    assign acc_data       = r_acc_data;

endmodule

`default_nettype wire

// File: rtl/tile_ram_arbiter.sv
// ============================================================================
//  Module      : tile_ram_arbiter
//  Description : Shares the registered-read port of the 256x12 tile RAM
//                between a display requester (16-pixel row bursts) and an
//                accelerator requester (single-word reads). Holds the
//                IDLE/BURST/SINGLE FSM, arbitration with one-burst fairness
//                for the accelerator (acc_owed), and the RAM address
//                register. Returned data is tagged back by tile_rd_pipe.
//  Config      : TILE_KEY_EN - enables the registered disp_pix_key flag
//                (disp_pix == KEY_COLOR); tied to 0 when undefined.
//  Ports       : clock, reset               - clock / sync active-high reset
//                disp_req, disp_row, disp_ack - display row request/grant
//                disp_pix_valid, disp_pix, disp_col, disp_done, disp_pix_key
//                                           - display pixel stream
//                acc_req, acc_addr, acc_ack - accelerator request/grant
//                acc_valid, acc_data        - accelerator read return
//                ram_address, ram_data_out  - tile RAM read port
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tile_ram_arbiter #(
    parameter int PIX_W = tile_ram_pkg::PIX_W
`ifdef TILE_KEY_EN
    ,
    parameter logic [PIX_W-1:0] KEY_COLOR = tile_ram_pkg::KEY_COLOR
`endif
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            disp_req,
    input  logic [3:0]                      disp_row,
    output logic                            disp_ack,
    output logic                            disp_pix_valid,
    output logic [PIX_W-1:0]                disp_pix,
    output logic [3:0]                      disp_col,
    output logic                            disp_done,
    output logic                            disp_pix_key,
    input  logic                            acc_req,
    input  logic [tile_ram_pkg::ADDR_W-1:0] acc_addr,
    output logic                            acc_ack,
    output logic                            acc_valid,
    output logic [PIX_W-1:0]                acc_data,
    output logic [tile_ram_pkg::ADDR_W-1:0] ram_address,
    input  logic [PIX_W-1:0]                ram_data_out
);
    import tile_ram_pkg::*;

    localparam logic [COL_W-1:0] c_LAST_COL = COL_W'(TILE_DIM - 1);

    state_t            r_state;
    logic [ADDR_W-1:0] r_ram_address;
    logic              r_disp_ack;
    logic              r_acc_ack;
    logic              r_acc_owed;
    logic              r_issue_valid;
    owner_t            r_issue_owner;
    logic              r_issue_last;

    logic              w_grant_disp;
    logic              w_grant_acc;
    logic [COL_W-1:0]  w_cur_col;

    // Display wins a tie unless it already went ahead of a waiting
    // accelerator request, which bounds the accelerator wait to one burst.
    assign w_grant_disp = disp_req && !(acc_req && r_acc_owed);
    assign w_grant_acc  = acc_req && !w_grant_disp;

    // During a burst the low address bits are the column being read.
    assign w_cur_col = r_ram_address[COL_W-1:0];

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= IDLE;
            r_ram_address <= '0;
            r_disp_ack    <= 1'b0;
            r_acc_ack     <= 1'b0;
            r_acc_owed    <= 1'b0;
            r_issue_valid <= 1'b0;
            r_issue_owner <= OWN_DISP;
            r_issue_last  <= 1'b0;
        end else begin
            r_disp_ack    <= 1'b0;
            r_acc_ack     <= 1'b0;
            r_issue_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_grant_disp) begin
                        r_state       <= BURST;
                        r_disp_ack    <= 1'b1;
                        r_ram_address <= {disp_row, {COL_W{1'b0}}};
                        r_issue_valid <= 1'b1;
                        r_issue_owner <= OWN_DISP;
                        r_issue_last  <= 1'b0;
                        if (acc_req) begin
                            r_acc_owed <= 1'b1;
                        end
                    end else if (w_grant_acc) begin
                        r_state       <= SINGLE;
                        r_acc_ack     <= 1'b1;
                        r_ram_address <= acc_addr;
                        r_issue_valid <= 1'b1;
                        r_issue_owner <= OWN_ACC;
                        r_issue_last  <= 1'b0;
                        r_acc_owed    <= 1'b0;
                    end
                end
                BURST: begin
                    // Column 15 is on the port this cycle: stop issuing and
                    // leave the address holding its last value.
                    if (w_cur_col == c_LAST_COL) begin
                        r_state <= IDLE;
                    end else begin
                        r_ram_address[COL_W-1:0] <= w_cur_col + COL_W'(1);
                        r_issue_valid            <= 1'b1;
                        r_issue_owner            <= OWN_DISP;
                        r_issue_last             <= (w_cur_col == c_LAST_COL - COL_W'(1));
                    end
                end
                SINGLE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    tile_rd_pipe #(
        .PIX_W        (PIX_W)
`ifdef TILE_KEY_EN
        ,
        .KEY_COLOR    (KEY_COLOR)
`endif
    ) u_rd_pipe (
        .clock          (clock),
        .reset          (reset),
        .issue_valid    (r_issue_valid),
        .issue_owner    (r_issue_owner),
        .issue_col      (w_cur_col),
        .issue_last     (r_issue_last),
        .ram_data_out   (ram_data_out),
        .disp_pix_valid (disp_pix_valid),
        .disp_pix       (disp_pix),
        .disp_col       (disp_col),
        .disp_done      (disp_done),
        .disp_pix_key   (disp_pix_key),
        .acc_valid      (acc_valid),
        .acc_data       (acc_data)
    );

    assign disp_ack    = r_disp_ack;
    assign acc_ack     = r_acc_ack;
    assign ram_address = r_ram_address;

endmodule

`default_nettype wire

// File: tb/tb_tile_ram_arbiter.sv
// ============================================================================
//  Module      : tb_tile_ram_arbiter
//  Description : Self-checking bench for tile_ram_arbiter. A behavioural tile
//                RAM answers the address port; a cycle-counting reference
//                model decides grants from the sampled requests and queues
//                the expected addresses, acks and returned words; a monitor
//                on the falling edge pops and compares.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_tile_ram_arbiter;

    localparam logic [11:0] KEY = 12'h247;

    logic        clock = 1'b0;
    logic        reset;
    logic        disp_req;
    logic [3:0]  disp_row;
    logic        disp_ack;
    logic        disp_pix_valid;
    logic [11:0] disp_pix;
    logic [3:0]  disp_col;
    logic        disp_done;
    logic        disp_pix_key;
    logic        acc_req;
    logic [7:0]  acc_addr;
    logic        acc_ack;
    logic        acc_valid;
    logic [11:0] acc_data;
    logic [7:0]  ram_address;
    logic [11:0] ram_data_out;

    always #5 clock = ~clock;

    tile_ram_arbiter dut (
        .clock          (clock),
        .reset          (reset),
        .disp_req       (disp_req),
        .disp_row       (disp_row),
        .disp_ack       (disp_ack),
        .disp_pix_valid (disp_pix_valid),
        .disp_pix       (disp_pix),
        .disp_col       (disp_col),
        .disp_done      (disp_done),
        .disp_pix_key   (disp_pix_key),
        .acc_req        (acc_req),
        .acc_addr       (acc_addr),
        .acc_ack        (acc_ack),
        .acc_valid      (acc_valid),
        .acc_data       (acc_data),
        .ram_address    (ram_address),
        .ram_data_out   (ram_data_out)
    );

    // Tile RAM: one-cycle registered read.
    logic [11:0] mem [256];
    always @(posedge clock) ram_data_out <= mem[ram_address];

    typedef struct { int cyc; logic [11:0] pix; logic [3:0] col; logic done; } disp_exp_t;
    typedef struct { int cyc; logic [11:0] data; } acc_exp_t;
    typedef struct { int cyc; logic [7:0] addr; } addr_exp_t;

    disp_exp_t dq[$];
    acc_exp_t  aq[$];
    addr_exp_t adq[$];

    int checks = 0;
    int errors = 0;

    // ---------------- reference model (rising edge) ----------------
    int   cyc      = 0;
    int   busy     = 0;   // edges left before the arbiter can grant again
    bit   owed     = 0;
    bit   rst_seen = 0;
    bit   exp_dack = 0;
    bit   exp_aack = 0;
    logic [7:0] m_a;

    always @(posedge clock) begin
        cyc      = cyc + 1;
        exp_dack = 0;
        exp_aack = 0;
        rst_seen = reset;
        if (reset) begin
            busy = 0;
            owed = 0;
            dq.delete();
            aq.delete();
            adq.delete();
        end else if (busy > 0) begin
            busy = busy - 1;
        end else if (disp_req && !(acc_req && owed)) begin
            exp_dack = 1;
            if (acc_req) owed = 1;
            busy = 16;
            for (int k = 0; k < 16; k++) begin
                m_a = {disp_row, 4'(k)};
                adq.push_back('{cyc + k, m_a});
                dq.push_back('{cyc + k + 2, mem[m_a], 4'(k), (k == 15)});
            end
        end else if (acc_req) begin
            exp_aack = 1;
            owed     = 0;
            busy     = 1;
            adq.push_back('{cyc, acc_addr});
            aq.push_back('{cyc + 2, mem[acc_addr]});
        end
    end

    // ---------------- monitor (falling edge) ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    logic [7:0] exp_addr = 8'd0;
    bit         ev;
    disp_exp_t  de;
    acc_exp_t   ae;

    always @(negedge clock) begin
        if (rst_seen) begin
            exp_addr = 8'd0;
            chk("reset_outputs",
                {disp_ack, disp_pix_valid, disp_pix, disp_col, disp_done, disp_pix_key,
                 acc_ack, acc_valid, acc_data, ram_address}, 64'd0);
        end else begin
            while (adq.size() > 0 && adq[0].cyc <= cyc) begin
                exp_addr = adq[0].addr;
                void'(adq.pop_front());
            end
            chk("ram_address", ram_address, exp_addr);
            chk("disp_ack", disp_ack, exp_dack);
            chk("acc_ack", acc_ack, exp_aack);

            ev = (dq.size() > 0) && (dq[0].cyc == cyc);
            chk("disp_pix_valid", disp_pix_valid, ev);
            if (ev) begin
                de = dq.pop_front();
                chk("disp_pix", disp_pix, de.pix);
                chk("disp_col", disp_col, de.col);
                chk("disp_done", disp_done, de.done);
`ifdef TILE_KEY_EN
                chk("disp_pix_key", disp_pix_key, (de.pix == KEY));
`else
                chk("disp_pix_key", disp_pix_key, 1'b0);
`endif
            end else begin
                chk("disp_done_idle", disp_done, 1'b0);
                chk("disp_pix_key_idle", disp_pix_key, 1'b0);
            end

            ev = (aq.size() > 0) && (aq[0].cyc == cyc);
            chk("acc_valid", acc_valid, ev);
            if (ev) begin
                ae = aq.pop_front();
                chk("acc_data", acc_data, ae.data);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_disp_ack();
        int n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!disp_ack && n < 200);
        checks++;
        if (!disp_ack) begin
            errors++;
            $display("FAIL disp_ack_timeout: got 0 expected 1 within 200 cycles");
        end
    endtask

    task automatic wait_acc_ack();
        int n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!acc_ack && n < 200);
        checks++;
        if (!acc_ack) begin
            errors++;
            $display("FAIL acc_ack_timeout: got 0 expected 1 within 200 cycles");
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 12'($urandom);
        for (int c = 0; c < 16; c++) mem[64 + c] = (c >= 6 && c <= 9) ? 12'h247 : 12'h888;
        mem[197] = 12'h247;

        reset    = 1'b1;
        disp_req = 1'b0;
        disp_row = 4'd0;
        acc_req  = 1'b0;
        acc_addr = 8'd0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        repeat (2) @(negedge clock);

        // Display row 4 fetch
        disp_row = 4'd4;
        disp_req = 1'b1;
        wait_disp_ack();
        disp_req = 1'b0;
        repeat (20) @(negedge clock);

        // Accelerator single read
        acc_addr = 8'd197;
        acc_req  = 1'b1;
        wait_acc_ack();
        acc_req = 1'b0;
        repeat (5) @(negedge clock);

        // Simultaneous requests held high across several grants
        disp_row = 4'd4;
        acc_addr = 8'($urandom);
        disp_req = 1'b1;
        acc_req  = 1'b1;
        repeat (45) @(negedge clock);
        disp_req = 1'b0;
        acc_req  = 1'b0;
        repeat (25) @(negedge clock);

        // Reset in C8 of a burst, then a clean refetch
        disp_row = 4'd9;
        disp_req = 1'b1;
        wait_disp_ack();
        disp_req = 1'b0;
        repeat (7) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        repeat (25) @(negedge clock);
        disp_row = 4'd4;
        disp_req = 1'b1;
        wait_disp_ack();
        disp_req = 1'b0;
        repeat (20) @(negedge clock);

        // Randomised traffic
        for (int c = 0; c < 3000; c++) begin
            @(negedge clock);
            if (reset) begin
                reset = 1'b0;
            end else if ($urandom_range(0, 599) == 0) begin
                reset    = 1'b1;
                disp_req = 1'b0;
                acc_req  = 1'b0;
            end else begin
                if (disp_req) begin
                    if (disp_ack) begin
                        if ($urandom_range(0, 1) == 0) disp_req = 1'b0;
                        else disp_row = 4'($urandom);
                    end else if ($urandom_range(0, 63) == 0) begin
                        disp_req = 1'b0;
                    end
                end else if ($urandom_range(0, 3) == 0) begin
                    disp_req = 1'b1;
                    disp_row = 4'($urandom);
                end
                if (acc_req) begin
                    if (acc_ack) begin
                        if ($urandom_range(0, 1) == 0) acc_req = 1'b0;
                        else acc_addr = 8'($urandom);
                    end else if ($urandom_range(0, 63) == 0) begin
                        acc_req = 1'b0;
                    end
                end else if ($urandom_range(0, 2) == 0) begin
                    acc_req  = 1'b1;
                    acc_addr = 8'($urandom);
                end
            end
        end

        reset    = 1'b0;
        disp_req = 1'b0;
        acc_req  = 1'b0;
        repeat (30) @(negedge clock);

        checks++;
        if (dq.size() + aq.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d outstanding returns expected 0", dq.size() + aq.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
